vis_accumulator: RTL and testbench

VIS_ACCUMULATOR -- requirements
Module: vis_accumulator

---
 rtl/vis_accumulator.sv | 164 ++++++++++++++++
 tb/tb_vis_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vis_accumulator.sv
// vis_accumulator: sums SUMS consecutive correlator frames of WORDS signed visibility words.
// The results are kept in an internal RAM and the summed frame is streamed out.
//
// Ports:
//   clock, reset                        rising-edge clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tlast/s_tdata   correlator input stream (IBITS signed words)
//   m_tvalid/m_tready/m_tlast/m_tdata   accumulated output stream (OBITS signed words)
//   frame_err                           sticky flag: s_tlast disagreed with the word index
//
// Build option: define VIS_ACCUM_SATURATE_EN to clamp sums instead of wrapping.

module vis_accumulator #(
    parameter int unsigned IBITS = 36,
    parameter int unsigned OBITS = 48,
    parameter int unsigned WORDS = 32,
    parameter int unsigned SUMS  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic [IBITS-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [OBITS-1:0] m_tdata,
    output logic             frame_err
);

    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned FW = (SUMS > 1) ? $clog2(SUMS) : 1;
    localparam logic [AW-1:0] LastAddr  = AW'(WORDS - 1);
    localparam logic [FW-1:0] LastFrame = FW'(SUMS - 1);

    typedef enum logic [0:0] {StAccum, StDrain} state_e;

    state_e           r_state;
    logic [AW-1:0]    r_addr;
    logic [FW-1:0]    r_frame;
    logic             r_frame_err;
    logic [OBITS-1:0] r_ram [WORDS];

    // Write-back stage of the read-modify-write pipeline
    logic             r_p_valid;
    logic             r_p_first;
    logic [AW-1:0]    r_p_addr;
    logic [OBITS-1:0] r_p_data;

    // Drain side
    logic [AW-1:0]    r_raddr;
    logic             r_m_valid;
    logic             r_m_last;
    logic [OBITS-1:0] r_m_data;

    logic             w_hs;
    logic             w_at_end;
    logic             w_frame_end;
    logic [OBITS-1:0] w_ext;
    logic [OBITS-1:0] w_old;
    logic [OBITS-1:0] w_add;
    logic [OBITS-1:0] w_wb;
    logic [OBITS-1:0] w_rd;
    logic             w_m_hs;

    assign w_hs        = s_tvalid && (r_state == StAccum);
    assign w_at_end    = (r_addr == LastAddr);
    assign w_frame_end = w_hs && (s_tlast || w_at_end);
    assign w_ext       = OBITS'(signed'(s_tdata));
    assign w_old       = r_ram[r_p_addr];

`ifdef VIS_ACCUM_SATURATE_EN
    localparam logic [OBITS-1:0] MaxVal = {1'b0, {(OBITS - 1){1'b1}}};
    localparam logic [OBITS-1:0] MinVal = {1'b1, {(OBITS - 1){1'b0}}};
    logic [OBITS:0] w_wide;
    logic           w_ovf;
    assign w_wide = {w_old[OBITS-1], w_old} + {r_p_data[OBITS-1], r_p_data};
    // Overflow shows up as disagreement between the guard bit and the result sign bit
    assign w_ovf  = w_wide[OBITS] ^ w_wide[OBITS-1];
    assign w_add  = w_ovf ? (w_wide[OBITS] ? MinVal : MaxVal) : w_wide[OBITS-1:0];
`else
    assign w_add  = w_old + r_p_data;
`endif

    // The first frame overwrites, so stale RAM contents never need clearing
    assign w_wb = r_p_first ? r_p_data : w_add;

    // Forward the in-flight write when the first drain read hits the same entry
    assign w_rd   = (r_p_valid && (r_p_addr == r_raddr)) ? w_wb : r_ram[r_raddr];
    assign w_m_hs = r_m_valid && m_tready;

    always_ff @(posedge clock) begin
        if (r_p_valid && !reset) begin
            r_ram[r_p_addr] <= w_wb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StAccum;
            r_addr      <= '0;
            r_frame     <= '0;
            r_frame_err <= 1'b0;
            r_p_valid   <= 1'b0;
            r_p_first   <= 1'b0;
            r_p_addr    <= '0;
            r_p_data    <= '0;
            r_raddr     <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_data    <= '0;
        end else begin
            r_p_valid <= w_hs;
            if (w_hs) begin
                r_p_first <= (r_frame == '0);
                r_p_addr  <= r_addr;
                r_p_data  <= w_ext;
            end

            unique case (r_state)
                StAccum: begin
                    if (w_hs) begin
                        if (s_tlast != w_at_end) begin
                            r_frame_err <= 1'b1;
                        end
                        if (w_frame_end) begin
                            r_addr <= '0;
                            if (r_frame == LastFrame) begin
                                r_frame <= '0;
                                r_state <= StDrain;
                                r_raddr <= '0;
                            end else begin
                                r_frame <= r_frame + FW'(1);
                            end
                        end else begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (w_m_hs && r_m_last) begin
                        r_state   <= StAccum;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end else if (!r_m_valid || m_tready) begin
                        // First load lands one cycle after entry, once the last write-back is done
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_rd;
                        r_m_last  <= (r_raddr == LastAddr);
                        r_raddr   <= (r_raddr == LastAddr) ? '0 : r_raddr + AW'(1);
                    end
                end
                default: r_state <= StAccum;
            endcase
        end
    end

    assign s_tready  = (r_state == StAccum);
    assign m_tvalid  = r_m_valid;
    assign m_tlast   = r_m_last;
    assign m_tdata   = r_m_data;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_vis_accumulator.sv
// Self-checking bench for vis_accumulator: a 4-word/3-sum instance with randomized traffic
// and a 4-bit/6-bit/8-sum instance for wrap and clamp behaviour.

module tb_vis_accumulator;

    localparam int IB = 36;
    localparam int OB = 48;
    localparam int NW = 4;
    localparam int NS = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          s_tvalid, s_tready, s_tlast;
    logic [IB-1:0] s_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [OB-1:0] m_tdata;
    logic          frame_err;

    logic          sm_s_tvalid, sm_s_tready, sm_s_tlast;
    logic [3:0]    sm_s_tdata;
    logic          sm_m_tvalid, sm_m_tready, sm_m_tlast;
    logic [5:0]    sm_m_tdata;
    logic          sm_frame_err;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint exp_sum [NW];

    always #5 clock = ~clock;

    vis_accumulator #(.IBITS(IB), .OBITS(OB), .WORDS(NW), .SUMS(NS)) dut (
        .clock(clock), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
        .frame_err(frame_err)
    );

    vis_accumulator #(.IBITS(4), .OBITS(6), .WORDS(4), .SUMS(8)) dut_sm (
        .clock(clock), .reset(reset),
        .s_tvalid(sm_s_tvalid), .s_tready(sm_s_tready), .s_tlast(sm_s_tlast),
        .s_tdata(sm_s_tdata),
        .m_tvalid(sm_m_tvalid), .m_tready(sm_m_tready), .m_tlast(sm_m_tlast),
        .m_tdata(sm_m_tdata),
        .frame_err(sm_frame_err)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Two's complement wrap of v to ob bits
    function automatic longint wrap_to(input longint v, input int ob);
        return (v <<< (64 - ob)) >>> (64 - ob);
    endfunction

    function automatic longint rand_word();
        longint r;
        r = {$urandom, $urandom};
        return wrap_to(r, IB);
    endfunction

    // Reset with a competing input handshake offered; the handshake must be ignored
    task automatic do_reset();
        s_tvalid = 1'b1;
        s_tdata  = IB'(rand_word());
        s_tlast  = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        s_tvalid = 1'b0;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", longint'(m_tdata), 0);
        check("rst_frame_err", frame_err, 0);
    endtask

    task automatic send_word(input longint d, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = IB'(d);
        s_tlast  = last;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // mode 0: random words, 1: word index + 1, 2: all ones
    task automatic send_run(input int mode, input int gap_pct);
        longint d;
        for (int f = 0; f < NS; f++) begin
            for (int w = 0; w < NW; w++) begin
                d = (mode == 0) ? rand_word() : (mode == 1) ? longint'(w + 1) : 64'sd1;
                exp_sum[w] = (f == 0) ? d : wrap_to(exp_sum[w] + d, OB);
                while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    s_tvalid = 1'b0;
                    tick();
                end
                check("s_tready_accum", s_tready, 1);
                send_word(d, w == NW - 1);
            end
        end
        check("m_tvalid_plus1", m_tvalid, 0);
        check("s_tready_drain", s_tready, 0);
        tick();
        check("m_tvalid_plus2", m_tvalid, 1);
    endtask

    // rmode 0: ready always, 1: toggling, 2: random; rst_after > 0 resets after that many words
    task automatic drain(input int rmode, input bit chk_data, input int rst_after);
        int   idx = 0;
        int   cyc = 0;
        bit   stalled = 0;
        logic hs;
        while (idx < NW && cyc < 200) begin
            m_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? logic'(cyc % 2 == 1)
                                                           : logic'($urandom_range(1));
            if (stalled) check("m_tvalid_hold", m_tvalid, 1);
            if (m_tvalid) begin
                check("s_tready_low", s_tready, 0);
                check("m_tlast", m_tlast, idx == NW - 1);
                if (chk_data) check("m_tdata", longint'($signed(m_tdata)), exp_sum[idx]);
            end
            stalled = m_tvalid && !m_tready;
            hs      = m_tvalid && m_tready;
            tick();
            cyc++;
            if (hs) begin
                idx++;
                if (idx == rst_after) begin
                    do_reset();
                    return;
                end
            end
        end
        if (idx < NW) check("drain_timeout", idx, NW);
        check("post_drain_m_tvalid", m_tvalid, 0);
        check("post_drain_s_tready", s_tready, 1);
    endtask

    task automatic run_small(input int v);
        longint total;
        longint exp_v;
        int     cyc;
        total = 8 * v;
`ifdef VIS_ACCUM_SATURATE_EN
        exp_v = (total > 31) ? 31 : (total < -32) ? -32 : total;
`else
        exp_v = wrap_to(total, 6);
`endif
        sm_m_tready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sm_s_tvalid = 1'b1;
            sm_s_tdata  = 4'(v);
            sm_s_tlast  = (i % 4 == 3);
            tick();
        end
        sm_s_tvalid = 1'b0;
        sm_s_tlast  = 1'b0;
        check("sm_m_tvalid_plus1", sm_m_tvalid, 0);
        tick();
        check("sm_m_tvalid_plus2", sm_m_tvalid, 1);
        sm_m_tready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            cyc = 0;
            while (!sm_m_tvalid && cyc < 20) begin
                tick();
                cyc++;
            end
            check("sm_m_tdata", longint'($signed(sm_m_tdata)), exp_v);
            check("sm_m_tlast", sm_m_tlast, w == 3);
            tick();
        end
        check("sm_post_m_tvalid", sm_m_tvalid, 0);
        sm_m_tready = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        s_tdata     = '0;
        m_tready    = 1'b0;
        sm_s_tvalid = 1'b0;
        sm_s_tlast  = 1'b0;
        sm_s_tdata  = '0;
        sm_m_tready = 1'b0;
        do_reset();

        // Back-to-back {1,2,3,4} frames -> {3,6,9,12}
        send_run(1, 0);
        drain(0, 1, -1);
        check("frame_err_clean", frame_err, 0);

        // Same pattern with toggling m_tready
        send_run(1, 30);
        drain(1, 1, -1);

        for (int k = 0; k < 4; k++) begin
            send_run(0, (k == 0) ? 0 : 25);
            drain(2, 1, -1);
        end

        // Reset after the second drain word, then a fresh run of ones
        send_run(0, 0);
        drain(0, 1, 2);
        send_run(2, 0);
        drain(0, 1, -1);

        // Early s_tlast on word 2; the short frame still counts toward the sum
        send_word(rand_word(), 1'b0);
        send_word(rand_word(), 1'b0);
        check("err_before", frame_err, 0);
        send_word(rand_word(), 1'b1);
        check("err_early_tlast", frame_err, 1);
        repeat (5) tick();
        check("err_sticky_idle", frame_err, 1);
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < NW; w++) send_word(rand_word(), w == NW - 1);
        end
        tick();
        check("err_frame_counted", m_tvalid, 1);
        drain(0, 0, -1);
        check("err_sticky_drain", frame_err, 1);
        do_reset();

        // Missing s_tlast on the final word
        for (int w = 0; w < NW; w++) send_word(rand_word(), 1'b0);
        check("err_missing_tlast", frame_err, 1);
        do_reset();

        run_small(7);
        run_small(-8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
